// File: rtl/sif_wr_bridge.sv
// ============================================================================
// Module   : sif_wr_bridge
// Purpose  : Bridges X-side access strobes to the W-side write port. X writes
//            are queued in a small FIFO and replayed as single-cycle W write
//            strobes with a programmable minimum spacing. X reads are served
//            from a shadow array that mirrors values already committed on W.
// Options  : SIF_WR_BRIDGE_OVF_CNT_EN adds ovf_cnt / ovf_sticky drop tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sif_wr_bridge #(
  parameter int DEPTH = 4,   // FIFO entries, power of 2, >= 2
  parameter int NREGS = 16,  // shadow registers, power of 2, >= 2
  parameter int GAP   = 0    // minimum low cycles between W strobes (0..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xa_wr_s,
  input  logic        xa_rd_s,
  input  logic [15:0] xa_addr,
  input  logic [15:0] xa_data_wr,
  output logic [15:0] xa_data_rd,
  output logic        xa_full,
  output logic        wa_wr_s,
  output logic [15:0] wa_addr,
  output logic [15:0] wa_data_wr
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
  ,
  output logic [7:0]  ovf_cnt,
  output logic        ovf_sticky
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NREGS);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [3:0]  GAP_C   = 4'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;

  // Sequencer and W-side outputs
  state_t        state_q, state_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          wa_wr_s_q, wa_wr_s_d;
  logic [15:0]   wa_addr_q, wa_addr_d;
  logic [15:0]   wa_data_q, wa_data_d;

  // Shadow array and read port
  logic [15:0]   shadow_q [NREGS];
  logic [15:0]   shadow_d [NREGS];
  logic [15:0]   rd_data_q, rd_data_d;

  logic          pop;
  logic          push_ok;
  logic          fifo_ne;
  logic [31:0]   head;

`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic          ovf_sticky_q, ovf_sticky_d;
`endif

  // Next-state logic: sequencer, FIFO pointers, shadow commit and read port
  always_comb begin
    fifo_ne   = (count_q != '0);
    head      = mem_q[rd_ptr_q];
    pop       = 1'b0;
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    wa_wr_s_d = 1'b0;
    wa_addr_d = wa_addr_q;
    wa_data_d = wa_data_q;

    case (state_q)
      ST_IDLE: begin
        if (fifo_ne) begin
          pop       = 1'b1;
          wa_wr_s_d = 1'b1;
          wa_addr_d = head[31:16];
          wa_data_d = head[15:0];
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (GAP == 0 && fifo_ne) begin
          pop       = 1'b1;
          wa_wr_s_d = 1'b1;
          wa_addr_d = head[31:16];
          wa_data_d = head[15:0];
        end else if (GAP <= 1) begin
          // The IDLE pop cycle alone provides a single low cycle.
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_C;
        end
      end
      ST_GAP: begin
        // The IDLE pop cycle is the last low cycle of the gap, so leave
        // here one cycle before the counter would reach 1.
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q <= 4'd2) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    push_ok  = xa_wr_s && ((count_q < DEPTH_C) || pop);
    count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    full_d   = (count_d == DEPTH_C);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // Commit of the strobe currently on the W side; reads see the old value.
    shadow_d = shadow_q;
    if (state_q == ST_WRITE) begin
      shadow_d[wa_addr_q[IW-1:0]] = wa_data_q;
    end
    rd_data_d = xa_rd_s ? shadow_q[xa_addr[IW-1:0]] : rd_data_q;

`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
    ovf_cnt_d    = ovf_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    if (xa_wr_s && !push_ok) begin
      ovf_sticky_d = 1'b1;
      if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end
`endif
  end

  // FIFO data store; contents behind the pointers need no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {xa_addr, xa_data_wr};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 4'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      wa_wr_s_q <= 1'b0;
      wa_addr_q <= 16'h0000;
      wa_data_q <= 16'h0000;
      rd_data_q <= 16'h0000;
      for (int i = 0; i < NREGS; i++) begin
        shadow_q[i] <= 16'h0000;
      end
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
      ovf_cnt_q    <= 8'd0;
      ovf_sticky_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      wa_wr_s_q <= wa_wr_s_d;
      wa_addr_q <= wa_addr_d;
      wa_data_q <= wa_data_d;
      rd_data_q <= rd_data_d;
      shadow_q  <= shadow_d;
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
      ovf_cnt_q    <= ovf_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
`endif
    end
  end

  assign xa_data_rd = rd_data_q;
  assign xa_full    = full_q;
  assign wa_wr_s    = wa_wr_s_q;
  assign wa_addr    = wa_addr_q;
  assign wa_data_wr = wa_data_q;
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
  assign ovf_cnt    = ovf_cnt_q;
  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sif_wr_bridge.sv
// ============================================================================
// Module   : tb_sif_wr_bridge
// Purpose  : Directed self-checking bench for sif_wr_bridge. Three instances
//            (GAP = 0, 2, 3) share the X-side stimulus; each scenario checks
//            the instance relevant to it.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sif_wr_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        xa_wr_s = 1'b0;
  logic        xa_rd_s = 1'b0;
  logic [15:0] xa_addr = 16'h0000;
  logic [15:0] xa_data_wr = 16'h0000;

  logic [15:0] g0_rd, g2_rd, g3_rd;
  logic        g0_full, g2_full, g3_full;
  logic        g0_wr, g2_wr, g3_wr;
  logic [15:0] g0_addr, g2_addr, g3_addr;
  logic [15:0] g0_data, g2_data, g3_data;
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
  logic [7:0]  g0_oc, g2_oc, g3_oc;
  logic        g0_os, g2_os, g3_os;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t q0[$];
  ev_t q2[$];
  ev_t q3[$];

  always #5 clk = ~clk;

  sif_wr_bridge #(.DEPTH(4), .NREGS(16), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_data_rd(g0_rd),
    .xa_full(g0_full), .wa_wr_s(g0_wr), .wa_addr(g0_addr), .wa_data_wr(g0_data)
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
    , .ovf_cnt(g0_oc), .ovf_sticky(g0_os)
`endif
  );

  sif_wr_bridge #(.DEPTH(4), .NREGS(16), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_data_rd(g2_rd),
    .xa_full(g2_full), .wa_wr_s(g2_wr), .wa_addr(g2_addr), .wa_data_wr(g2_data)
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
    , .ovf_cnt(g2_oc), .ovf_sticky(g2_os)
`endif
  );

  sif_wr_bridge #(.DEPTH(4), .NREGS(16), .GAP(3)) u_g3 (
    .clk(clk), .rst(rst), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_data_rd(g3_rd),
    .xa_full(g3_full), .wa_wr_s(g3_wr), .wa_addr(g3_addr), .wa_data_wr(g3_data)
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
    , .ovf_cnt(g3_oc), .ovf_sticky(g3_os)
`endif
  );

  // Cycle counter and W-side strobe recorder (sampled mid-cycle)
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (g0_wr) q0.push_back('{cyc, g0_addr, g0_data});
    if (g2_wr) q2.push_back('{cyc, g2_addr, g2_data});
    if (g3_wr) q3.push_back('{cyc, g3_addr, g3_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    xa_wr_s = 1'b0;
    xa_rd_s = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete();
    q2.delete();
    q3.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (g0_wr !== 1'b0) begin fails++; $display("FAIL reset_wr_s actual=%0h expected=0", g0_wr); end
    tests++; if (g3_addr !== 16'h0000) begin fails++; $display("FAIL reset_wa_addr actual=%h expected=0000", g3_addr); end
    tests++; if (g3_data !== 16'h0000) begin fails++; $display("FAIL reset_wa_data actual=%h expected=0000", g3_data); end
    tests++; if (g2_rd !== 16'h0000) begin fails++; $display("FAIL reset_xa_data_rd actual=%h expected=0000", g2_rd); end
    tests++; if (g0_full !== 1'b0) begin fails++; $display("FAIL reset_xa_full actual=%0h expected=0", g0_full); end
  endtask

  task automatic test_single_write();
    do_reset();
    xa_wr_s = 1'b1; xa_addr = 16'h0003; xa_data_wr = 16'hBEEF;
    tick();
    xa_wr_s = 1'b0;
    tests++; if (g0_wr !== 1'b0) begin fails++; $display("FAIL single_early_strobe actual=%0h expected=0", g0_wr); end
    tick();
    tests++; if (g0_wr !== 1'b1) begin fails++; $display("FAIL single_strobe actual=%0h expected=1", g0_wr); end
    tests++; if (g0_addr !== 16'h0003) begin fails++; $display("FAIL single_addr actual=%h expected=0003", g0_addr); end
    tests++; if (g0_data !== 16'hBEEF) begin fails++; $display("FAIL single_data actual=%h expected=beef", g0_data); end
    tick();
    tests++; if (g0_wr !== 1'b0) begin fails++; $display("FAIL single_strobe_len actual=%0h expected=0", g0_wr); end
    tests++; if (g0_data !== 16'hBEEF) begin fails++; $display("FAIL single_data_hold actual=%h expected=beef", g0_data); end
    tick();
    xa_rd_s = 1'b1; xa_addr = 16'h0003;
    tick();
    xa_rd_s = 1'b0;
    tests++; if (g0_rd !== 16'hBEEF) begin fails++; $display("FAIL single_readback actual=%h expected=beef", g0_rd); end
    tick();
    tests++; if (g0_rd !== 16'hBEEF) begin fails++; $display("FAIL single_read_hold actual=%h expected=beef", g0_rd); end
  endtask

  task automatic test_back_to_back();
    logic full_seen;
    full_seen = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      xa_wr_s = 1'b1; xa_addr = 16'(16'h0010 + i); xa_data_wr = 16'(i);
      tick();
      full_seen = full_seen | g0_full;
    end
    xa_wr_s = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      full_seen = full_seen | g0_full;
    end
    tests++; if (full_seen !== 1'b0) begin fails++; $display("FAIL b2b_full actual=%0h expected=0", full_seen); end
    tests++; if (q0.size() != 4) begin fails++; $display("FAIL b2b_count actual=%0d expected=4", q0.size()); end
    if (q0.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        tests++; if (q0[k].d !== 16'(k + 1)) begin fails++; $display("FAIL b2b_data%0d actual=%h expected=%h", k, q0[k].d, 16'(k + 1)); end
        tests++; if (q0[k].cyc != q0[0].cyc + k) begin fails++; $display("FAIL b2b_spacing%0d actual=%0d expected=%0d", k, q0[k].cyc - q0[0].cyc, k); end
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      xa_wr_s = 1'b1; xa_addr = 16'(16'h0020 + i); xa_data_wr = 16'(16'hA000 + i);
      tick();
    end
    xa_wr_s = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    tests++; if (q2.size() != 3) begin fails++; $display("FAIL gap_count actual=%0d expected=3", q2.size()); end
    if (q2.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        tests++; if (q2[k].d !== 16'(16'hA001 + k)) begin fails++; $display("FAIL gap_data%0d actual=%h expected=%h", k, q2[k].d, 16'(16'hA001 + k)); end
      end
      for (int k = 1; k < 3; k++) begin
        // Two low cycles between pulses means a pulse every third cycle.
        tests++; if (q2[k].cyc - q2[k-1].cyc != 3) begin fails++; $display("FAIL gap_spacing%0d actual=%0d expected=3", k, q2[k].cyc - q2[k-1].cyc); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    // GAP=3 instance: pushes 0..5 are accepted (push 5 rides on the IDLE pop),
    // pushes 6 and 7 arrive while full with no pop and are dropped.
    for (int i = 0; i < 8; i++) begin
      xa_wr_s = 1'b1; xa_addr = 16'(16'h0030 + i); xa_data_wr = 16'(16'h0100 + i);
      tick();
      if (i == 4) begin
        tests++; if (g3_full !== 1'b1) begin fails++; $display("FAIL ovf_full actual=%0h expected=1", g3_full); end
      end
    end
    xa_wr_s = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    tests++; if (g3_full !== 1'b0) begin fails++; $display("FAIL ovf_full_clear actual=%0h expected=0", g3_full); end
    tests++; if (q3.size() != 6) begin fails++; $display("FAIL ovf_count actual=%0d expected=6", q3.size()); end
    if (q3.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        tests++; if (q3[k].d !== 16'(16'h0100 + k) || q3[k].a !== 16'(16'h0030 + k)) begin
          fails++; $display("FAIL ovf_entry%0d actual=%h/%h expected=%h/%h", k, q3[k].a, q3[k].d, 16'(16'h0030 + k), 16'(16'h0100 + k));
        end
      end
      tests++; if (q3[1].cyc - q3[0].cyc != 4) begin fails++; $display("FAIL ovf_spacing actual=%0d expected=4", q3[1].cyc - q3[0].cyc); end
    end
`ifdef SIF_WR_BRIDGE_OVF_CNT_EN
    tests++; if (g3_oc !== 8'd2) begin fails++; $display("FAIL ovf_cnt actual=%0d expected=2", g3_oc); end
    tests++; if (g3_os !== 1'b1) begin fails++; $display("FAIL ovf_sticky actual=%0h expected=1", g3_os); end
    tests++; if (g0_os !== 1'b0) begin fails++; $display("FAIL ovf_sticky_g0 actual=%0h expected=0", g0_os); end
`endif
  endtask

  task automatic test_collision();
    do_reset();
    xa_wr_s = 1'b1; xa_addr = 16'h0005; xa_data_wr = 16'h1234;
    tick();
    xa_wr_s = 1'b0;
    tick();
    tests++; if (g0_wr !== 1'b1) begin fails++; $display("FAIL coll_in_write actual=%0h expected=1", g0_wr); end
    xa_rd_s = 1'b1; xa_addr = 16'h0005;
    tick();
    tests++; if (g0_rd !== 16'h0000) begin fails++; $display("FAIL coll_old_value actual=%h expected=0000", g0_rd); end
    tick();
    xa_rd_s = 1'b0;
    tests++; if (g0_rd !== 16'h1234) begin fails++; $display("FAIL coll_new_value actual=%h expected=1234", g0_rd); end
  endtask

  task automatic test_addr_alias();
    do_reset();
    xa_wr_s = 1'b1; xa_addr = 16'hAB05; xa_data_wr = 16'h5555;
    tick();
    xa_wr_s = 1'b0;
    tick();
    tests++; if (g0_addr !== 16'hAB05) begin fails++; $display("FAIL alias_wa_addr actual=%h expected=ab05", g0_addr); end
    tick();
    xa_rd_s = 1'b1; xa_addr = 16'h0005;
    tick();
    xa_rd_s = 1'b0;
    tests++; if (g0_rd !== 16'h5555) begin fails++; $display("FAIL alias_read actual=%h expected=5555", g0_rd); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      xa_wr_s = 1'b1; xa_addr = 16'(16'h0040 + i); xa_data_wr = 16'(16'h0F00 + i);
      tick();
    end
    xa_wr_s = 1'b0;
    // GAP=3 instance: one entry committed, three still queued.
    tests++; if (g3_wr !== 1'b0 || q3.size() != 1) begin fails++; $display("FAIL mid_pre_state actual=%0h/%0d expected=0/1", g3_wr, q3.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q3.delete();
    tests++; if (g3_wr !== 1'b0) begin fails++; $display("FAIL mid_post_reset_strobe actual=%0h expected=0", g3_wr); end
    for (int i = 0; i < 30; i++) tick();
    tests++; if (q3.size() != 0) begin fails++; $display("FAIL mid_no_strobes actual=%0d expected=0", q3.size()); end
    tests++; if (g3_full !== 1'b0) begin fails++; $display("FAIL mid_full actual=%0h expected=0", g3_full); end
    for (int i = 0; i < 4; i++) begin
      xa_rd_s = 1'b1; xa_addr = 16'(16'h0040 + i);
      tick();
      tests++; if (g3_rd !== 16'h0000) begin fails++; $display("FAIL mid_shadow%0d actual=%h expected=0000", i, g3_rd); end
    end
    xa_rd_s = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_gap();
    test_overflow();
    test_collision();
    test_addr_alias();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
